// File: rtl/gray_step_counter.sv
// gray_step_counter
//   Turns each rising edge of a divided clock into one step of a WIDTH-bit
//   Gray-code counter. The divided clock is a same-domain level on clk_i.
//   It is edge-detected and is never used as a clock.
//
// Ports
//   clk_i       system clock (same clock that feeds the divider)
//   rst_i       synchronous reset, active high
//   clk_div_i   divided clock, already registered on clk_i upstream
//   en_i        count enable (0 = hold); sampled only in the tick cycle
//   up_i        direction (1 = increment, 0 = decrement)
//   load_i      parallel-load strobe; wins over counting
//   load_val_i  binary value to load
//   gray_o      registered Gray code of the count
//   bin_o       registered binary count
//   tc_o        one-cycle pulse on a counted wrap-around (never on a load)
//   step_o      one-cycle pulse whenever a load or a counted step happens
//   err_o       (GRAY_STEP_CHECK_EN only) sticky flag, set when a counted
//               step changes more or fewer than one Gray bit
//
// Build option
//   GRAY_STEP_CHECK_EN : adds err_o and the one-bit-change checker.
module gray_step_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_div_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tc_o,
  output logic             step_o
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             err_o
`endif
);

  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

  // What happens to the count on this clk_i edge.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_UP   = 2'd2,
    ST_DN   = 2'd3
  } step_e;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             step_q, step_d;
  logic             div_q, div_d;
  logic             tick;
  step_e            kind;

  always_comb begin
    div_d  = clk_div_i;
    // div_q clears on reset, so a high clk_div_i right after reset still ticks.
    tick   = clk_div_i & ~div_q;
    kind   = ST_HOLD;
    bin_d  = bin_q;
    tc_d   = 1'b0;
    step_d = 1'b0;

    if (load_i)            kind = ST_LOAD;
    else if (tick && en_i) kind = up_i ? ST_UP : ST_DN;

    case (kind)
      ST_LOAD: begin
        bin_d  = load_val_i;
        step_d = 1'b1;
      end
      ST_UP: begin
        bin_d  = bin_q + WIDTH'(1);
        tc_d   = &bin_q;
        step_d = 1'b1;
      end
      ST_DN: begin
        bin_d  = bin_q - WIDTH'(1);
        tc_d   = ~|bin_q;
        step_d = 1'b1;
      end
      default: ;
    endcase

    // Gray is derived from the next binary value so both outputs register
    // on the same edge and always agree.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      tc_q   <= 1'b0;
      step_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
      step_q <= step_d;
      div_q  <= div_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign tc_o   = tc_q;
  assign step_o = step_q;

`ifdef GRAY_STEP_CHECK_EN
  logic err_q, err_d;
  logic chk_bad;

  // Loads may jump arbitrarily; only counted steps must flip exactly one bit.
  always_comb begin
    chk_bad = ((kind == ST_UP) || (kind == ST_DN)) &&
              ($countones(gray_q ^ gray_d) != 1);
    err_d   = err_q | chk_bad;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;

  a_gray_one_bit: assert property (@(posedge clk_i) disable iff (rst_i) !chk_bad)
    else $error("gray_step_counter: counted step changed %0d gray bits (%b -> %b)",
                $countones(gray_q ^ gray_d), gray_q, gray_d);
`endif

endmodule

// File: doc/gray_step_counter.md
Name: gray_step_counter

Overview:
- Consumes the divided clock produced by the frequency-divider stage and turns each rising edge of it into one step of a WIDTH-bit Gray-code counter.
- Operates entirely in the fast clk_i domain. The divided clock is treated as a same-domain level signal and edge-detected; it is never used as a clock.
- Provides up/down counting, hold, parallel load, and a terminal-count pulse.
- Its Gray output drives the board LEDs/display stage.

Parameters:
- WIDTH, 4, counter width in bits (legal 2..16).
- INIT_VAL, 0, binary value loaded at reset.

Ports:
- clk_i  in  1  system clock (fast clock, same clock that feeds the divider).
- rst_i  in  1  synchronous reset, active-high.
- clk_div_i  in  1  divided clock from the divider stage, registered on clk_i upstream.
- en_i  in  1  count enable; 0 = hold.
- up_i  in  1  direction; 1 = increment, 0 = decrement.
- load_i  in  1  parallel-load strobe.
- load_val_i  in  WIDTH  binary value to load.
- gray_o  out  WIDTH  registered Gray code of the count.
- bin_o  out  WIDTH  registered binary count.
- tc_o  out  1  one-cycle pulse on wrap-around.
- step_o  out  1  one-cycle pulse whenever the count changed.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high; it is sampled only on the rising edge of clk_i.
- Reset values:
  - bin_o = INIT_VAL; gray_o = INIT_VAL ^ (INIT_VAL >> 1).
  - tc_o = 0; step_o = 0.
  - Edge-detect register div_q = 0.
- Reset has priority over everything, including mid-run; the count restarts at INIT_VAL on the next edge.
- Edge detection:
  - div_q <= clk_div_i every cycle.
  - tick = clk_div_i & ~div_q.
  - Exactly one tick per divided-clock period. No tick while clk_div_i stays high.
  - First cycle after reset release: if clk_div_i = 1, a tick fires, because div_q = 0.
- Two states:
  - HOLD (en_i = 0): a tick is ignored.
  - RUN (en_i = 1): a tick produces one step.
  - en_i is sampled in the tick cycle only.
- Next-value priority, evaluated per clk_i edge, highest first:
  1. load_i = 1: next = load_val_i, step_o = 1, tc_o = 0. Load acts regardless of tick and en_i.
  2. tick & en_i & up_i: next = bin + 1 modulo 2^WIDTH.
  3. tick & en_i & ~up_i: next = bin - 1 modulo 2^WIDTH.
  4. Otherwise: hold, step_o = 0, tc_o = 0.
- Latency: bin_o and gray_o both update on the clk_i edge that ends the tick (or load) cycle, i.e. 1 clk_i after clk_div_i rises at the input.
  - gray_o is computed from next, not from the old bin_o, so gray_o and bin_o are always consistent.
  - No combinational path from inputs to outputs.
- Wrap-around:
  - Up from 2^WIDTH-1 gives 0 with tc_o = 1 for that one cycle.
  - Down from 0 gives 2^WIDTH-1 with tc_o = 1.
  - tc_o never asserts on load, even if load_val_i equals a boundary value.
- Direction change between ticks takes effect at the next tick. No glitch, no skipped value.
- Gray property: consecutive counted steps differ in exactly one bit of gray_o, including across a wrap. Loads may change any number of bits.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- When defined:
  - Adds output port err_o (1 bit, reset 0).
  - On every counted step (not loads), err_o is set sticky if the popcount of old gray ^ new gray ≠ 1.
  - err_o clears only on rst_i.
  - A $display-style error message is printed in simulation.
- When undefined: port err_o is absent, and no checker logic is synthesized.

Test Plan:
- Reset: hold rst_i = 1 for 3 clk_i with INIT_VAL = 0 → bin_o = 0, gray_o = 0000, tc_o = 0, step_o = 0.
- Count up: en_i = 1, up_i = 1, clk_div_i toggling every 4 clk_i, 16 ticks → gray_o sequence 0000, 0001, 0011, 0010, 0110, … 1000, then 0000.
  - tc_o = 1 exactly on the 1000 → 0000 step.
  - step_o = 1 once per clk_div_i rising edge.
- Count down with wrap: bin_o = 0, up_i = 0, one tick → bin_o = 15, gray_o = 1000, tc_o = 1.
- Load collision: load_i = 1 with load_val_i = 9 in the same cycle as a tick → bin_o = 9, gray_o = 1101, tc_o = 0, no increment.
- Hold: en_i = 0 across 5 divided-clock edges → bin_o unchanged, step_o = 0.
  - en_i = 1 → next tick advances by exactly 1.
- Reset mid-run at bin_o = 6 with clk_div_i high → next edge bin_o = 0; one tick fires on the following cycle if clk_div_i is still high; with GRAY_STEP_CHECK_EN defined, err_o stays 0 through the entire run.
